fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The block SHALL have the parameter ADDR_W, default 32, meaning the instruction address and data width.
REQ-002 The block SHALL have the parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-003 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have the port rst, input, 1 bit: the reset, which is asynchronous and active-low.
REQ-005 The block SHALL have the port branch_en_i, input, 1 bit: a one-cycle redirect request.
REQ-006 The block SHALL have the port branch_target_i, input, ADDR_W bits: the redirect address.
REQ-007 The block SHALL have the port stall_i, input, 1 bit: downstream is not accepting inst_o this cycle.
REQ-008 The block SHALL have the port imem_ack_i, input, 1 bit: instruction memory returns data this cycle.
REQ-009 The block SHALL have the port imem_data_i, input, ADDR_W bits: the instruction word, valid when imem_ack_i=1.
REQ-010 The block SHALL have the port imem_req_o, output, 1 bit: the fetch request.
REQ-011 The block SHALL have the port imem_addr_o, output, ADDR_W bits: the fetch address, equal to the internal pc.
REQ-012 The block SHALL have the port inst_valid_o, output, 1 bit: the output slot holds an instruction.
REQ-013 The block SHALL have the port inst_o, output, ADDR_W bits: the instruction word in the output slot.
REQ-014 The block SHALL have the port inst_pc_o, output, ADDR_W bits: the address of inst_o.

Function
REQ-015 The FSM SHALL have exactly the states BOOT, FETCH, HOLD and DRAIN, with imem_req_o=1 in FETCH and DRAIN only.
REQ-016 In BOOT, the block SHALL go unconditionally to FETCH on the next edge.
REQ-017 While imem_req_o=1 and imem_ack_i=0, imem_addr_o SHALL stay constant.
REQ-018 The downstream slot SHALL be consumed on an edge where inst_valid_o=1 and stall_i=0, and the slot is free if inst_valid_o=0 or it is consumed that edge.
REQ-019 On a FETCH ack with the slot free and no branch, the block SHALL load inst_o<=imem_data_i, inst_pc_o<=pc, inst_valid_o<=1, pc<=pc+4, and stay in FETCH, giving a throughput of 1 instruction/cycle with a same-cycle ack.
REQ-020 On a FETCH ack with the slot not free and no branch, the block SHALL capture the data and pc into a 1-entry hold buffer, set pc<=pc+4, and go to HOLD.
REQ-021 In HOLD, when the slot is consumed, the block SHALL move the hold buffer into the slot (inst_valid_o stays 1) and go to FETCH.
REQ-022 When the slot is consumed and no new instruction loads that edge, the block SHALL set inst_valid_o<=0.
REQ-023 pc+4 SHALL be computed modulo 2^ADDR_W, so that 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-024 A branch SHALL load pc<=branch_target_i with bits [1:0] forced to 0.
REQ-025 branch_en_i SHALL have priority over every other event.
REQ-026 On a branch, the block SHALL clear inst_valid_o and the hold buffer on the same edge, whether or not stall_i is asserted.
REQ-027 A branch in FETCH with imem_ack_i=1 SHALL discard the returned data and stay in FETCH at the target.
REQ-028 A branch in FETCH with imem_ack_i=0 SHALL go to DRAIN.
REQ-029 In DRAIN, the block SHALL keep imem_req_o=1 at the old address, and on ack discard the data and go to FETCH at the redirected pc.
REQ-030 A branch in DRAIN SHALL overwrite the pending target (latest wins) and stay in DRAIN.
REQ-031 A branch in HOLD SHALL go to FETCH at the target.
REQ-032 A branch in BOOT SHALL load pc, and the first fetch SHALL use the target.
REQ-033 imem_ack_i SHALL be ignored in BOOT and HOLD.

Reset
REQ-034 On assertion of rst (rst=0), the block SHALL go immediately to BOOT, independent of clk, with pc=RESET_PC, imem_req_o=0, inst_valid_o=0, inst_o=0, inst_pc_o=0, and the hold buffer cleared.
REQ-035 On reset mid-transaction, the block SHALL drop imem_req_o asynchronously, and SHALL ignore any later ack for the aborted request.
REQ-036 On the first edge after rst deasserts, the block SHALL go from BOOT to FETCH, with the first request one cycle after reset release.

Verification
REQ-037 Reset release, ack tied to 1, stall=0 -> requests at 0x0, 0x4, 0x8 on consecutive cycles; inst_pc_o follows one cycle later.
REQ-038 A slot at 0x4 held by stall=1 while ack arrives for 0x8 -> HOLD entered, req=0; stall drops -> slot shows 0x8, req resumes at 0xC.
REQ-039 Branch to 0x103 while a request to 0x10 is pending with ack delayed 3 cycles -> DRAIN keeps addr 0x10, data discarded, next request at 0x100, inst_valid_o=0 throughout.
REQ-040 Branch and ack in the same cycle with stall=1 -> slot cleared, data dropped, next request at the target.
REQ-041 pc=0xFFFF_FFFC acked -> next request at 0x0000_0000.
REQ-042 rst pulsed low between clock edges during DRAIN -> req=0 immediately; after release, the first request is at RESET_PC.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: drives a pc-addressed memory request and feeds a
// single-entry output slot, with a one-entry hold buffer for back-pressure and branch redirect.
//
// state | meaning
// BOOT  | post-reset, no request; next edge starts fetching
// FETCH | request at pc; acked data goes to slot or hold buffer
// HOLD  | slot full and hold buffer full; no request until slot drains
// DRAIN | redirect pending; wait out the old request, then fetch at target
module fetch_ctrl #(
    parameter int                 ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(32'h0000_0000)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              branch_en_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    input  logic              stall_i,
    input  logic              imem_ack_i,
    input  logic [ADDR_W-1:0] imem_data_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic              inst_valid_o,
    output logic [ADDR_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o
);

    typedef enum logic [1:0] {BOOT, FETCH, HOLD, DRAIN} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic [ADDR_W-1:0] tgt, tgt_n;
    logic [ADDR_W-1:0] hold_data, hold_data_n;
    logic [ADDR_W-1:0] hold_pc, hold_pc_n;
    logic [ADDR_W-1:0] slot, slot_n;
    logic [ADDR_W-1:0] slot_pc, slot_pc_n;
    logic              valid, valid_n;
    logic              consume;
    logic              slot_free;
    logic [ADDR_W-1:0] br_tgt;

    assign consume     = valid & ~stall_i;
    assign slot_free   = ~valid | consume;
    assign br_tgt      = {branch_target_i[ADDR_W-1:2], 2'b00};

    // Request is decoded from state alone so an async reset drops it at once.
    assign imem_req_o   = (state == FETCH) || (state == DRAIN);
    assign imem_addr_o  = pc;
    assign inst_valid_o = valid;
    assign inst_o       = slot;
    assign inst_pc_o    = slot_pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= BOOT;
            pc        <= RESET_PC;
            tgt       <= '0;
            hold_data <= '0;
            hold_pc   <= '0;
            slot      <= '0;
            slot_pc   <= '0;
            valid     <= 1'b0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            tgt       <= tgt_n;
            hold_data <= hold_data_n;
            hold_pc   <= hold_pc_n;
            slot      <= slot_n;
            slot_pc   <= slot_pc_n;
            valid     <= valid_n;
        end
    end

    always_comb begin
        state_n     = state;
        pc_n        = pc;
        tgt_n       = tgt;
        hold_data_n = hold_data;
        hold_pc_n   = hold_pc;
        slot_n      = slot;
        slot_pc_n   = slot_pc;
        valid_n     = valid & ~consume;

        case (state)
            BOOT: begin
                state_n = FETCH;
                if (branch_en_i) pc_n = br_tgt;
            end
            FETCH: begin
                if (branch_en_i) begin
                    if (imem_ack_i) begin
                        pc_n = br_tgt;
                    end else begin
                        tgt_n   = br_tgt;
                        state_n = DRAIN;
                    end
                end else if (imem_ack_i) begin
                    if (slot_free) begin
                        slot_n    = imem_data_i;
                        slot_pc_n = pc;
                        valid_n   = 1'b1;
                    end else begin
                        hold_data_n = imem_data_i;
                        hold_pc_n   = pc;
                        state_n     = HOLD;
                    end
                    pc_n = pc + ADDR_W'(4);
                end
            end
            HOLD: begin
                if (branch_en_i) begin
                    pc_n    = br_tgt;
                    state_n = FETCH;
                end else if (consume) begin
                    slot_n    = hold_data;
                    slot_pc_n = hold_pc;
                    valid_n   = 1'b1;
                    state_n   = FETCH;
                end
            end
            DRAIN: begin
                // Old address stays on the bus until its ack; that data is dropped.
                if (branch_en_i) begin
                    tgt_n = br_tgt;
                end else if (imem_ack_i) begin
                    pc_n    = tgt;
                    state_n = FETCH;
                end
            end
            default: state_n = BOOT;
        endcase

        if (branch_en_i) begin
            valid_n     = 1'b0;
            hold_data_n = '0;
            hold_pc_n   = '0;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: memory returns a fixed function of the address,
// delivered instructions are checked against a queue of expected pcs.
module tb_fetch_ctrl;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              branch_en_i = 1'b0;
    logic [ADDR_W-1:0] branch_target_i = '0;
    logic              stall_i = 1'b0;
    logic              imem_ack_i = 1'b0;
    logic [ADDR_W-1:0] imem_data_i;
    logic              imem_req_o;
    logic [ADDR_W-1:0] imem_addr_o;
    logic              inst_valid_o;
    logic [ADDR_W-1:0] inst_o;
    logic [ADDR_W-1:0] inst_pc_o;

    int vectors = 0;
    int miscompares = 0;
    logic [ADDR_W-1:0] exp_q[$];

    function automatic logic [ADDR_W-1:0] mem(input logic [ADDR_W-1:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    assign imem_data_i = mem(imem_addr_o);

    always #5 clk = ~clk;

    fetch_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk(clk),
        .rst(rst),
        .branch_en_i(branch_en_i),
        .branch_target_i(branch_target_i),
        .stall_i(stall_i),
        .imem_ack_i(imem_ack_i),
        .imem_data_i(imem_data_i),
        .imem_req_o(imem_req_o),
        .imem_addr_o(imem_addr_o),
        .inst_valid_o(inst_valid_o),
        .inst_o(inst_o),
        .inst_pc_o(inst_pc_o)
    );

    task automatic chk(input string tag, input logic [ADDR_W-1:0] obs, input logic [ADDR_W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Compare the output slot against the oldest expected instruction.
    task automatic pop_slot(input string tag);
        logic [ADDR_W-1:0] e;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s observed=slot expected=queue_entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_valid"}, {31'd0, inst_valid_o}, 32'd1);
            chk({tag, "_pc"}, inst_pc_o, e);
            chk({tag, "_data"}, inst_o, mem(e));
        end
    endtask

    initial begin
        #2;
        chk("rst_req", {31'd0, imem_req_o}, 32'd0);
        chk("rst_valid", {31'd0, inst_valid_o}, 32'd0);
        chk("rst_inst", inst_o, 32'd0);
        chk("rst_inst_pc", inst_pc_o, 32'd0);
        chk("rst_addr", imem_addr_o, 32'd0);

        @(negedge clk);
        rst = 1'b1;
        chk("boot_req", {31'd0, imem_req_o}, 32'd0);
        cyc();
        chk("first_req", {31'd0, imem_req_o}, 32'd1);
        chk("first_addr", imem_addr_o, 32'h0);
        chk("first_valid", {31'd0, inst_valid_o}, 32'd0);

        // Streaming with ack tied high
        imem_ack_i = 1'b1;
        exp_q.push_back(32'h0);
        cyc();
        chk("stream_addr4", imem_addr_o, 32'h4);
        pop_slot("stream0");
        exp_q.push_back(32'h4);
        cyc();
        chk("stream_addr8", imem_addr_o, 32'h8);

        // Stall with slot at 0x4 while 0x8 is acked
        stall_i = 1'b1;
        exp_q.push_back(32'h8);
        cyc();
        chk("hold_req", {31'd0, imem_req_o}, 32'd0);
        chk("hold_slot_pc", inst_pc_o, 32'h4);
        chk("hold_addr", imem_addr_o, 32'hC);
        cyc();
        chk("hold_ack_ignored", {31'd0, imem_req_o}, 32'd0);
        chk("hold_slot_pc2", inst_pc_o, 32'h4);
        stall_i = 1'b0;
        imem_ack_i = 1'b0;
        pop_slot("slot4");
        cyc();
        pop_slot("slot8");
        chk("resume_req", {31'd0, imem_req_o}, 32'd1);
        chk("resume_addr", imem_addr_o, 32'hC);
        imem_ack_i = 1'b1;
        exp_q.push_back(32'hC);
        cyc();
        pop_slot("slotC");
        imem_ack_i = 1'b0;
        cyc();
        chk("pend_addr", imem_addr_o, 32'h10);
        chk("pend_valid", {31'd0, inst_valid_o}, 32'd0);

        // Redirect while the 0x10 request is outstanding
        branch_en_i = 1'b1;
        branch_target_i = 32'h103;
        cyc();
        branch_en_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("drain_req", {31'd0, imem_req_o}, 32'd1);
            chk("drain_addr", imem_addr_o, 32'h10);
            chk("drain_valid", {31'd0, inst_valid_o}, 32'd0);
            cyc();
        end
        chk("drain_addr_last", imem_addr_o, 32'h10);
        imem_ack_i = 1'b1;
        cyc();
        chk("redir_addr", imem_addr_o, 32'h100);
        chk("redir_valid", {31'd0, inst_valid_o}, 32'd0);
        exp_q.push_back(32'h100);
        cyc();

        // Branch and ack together while stalled
        stall_i = 1'b1;
        pop_slot("slot100");
        branch_en_i = 1'b1;
        branch_target_i = 32'h200;
        cyc();
        chk("bra_valid", {31'd0, inst_valid_o}, 32'd0);
        chk("bra_addr", imem_addr_o, 32'h200);
        chk("bra_req", {31'd0, imem_req_o}, 32'd1);
        stall_i = 1'b0;

        // Address wrap
        branch_target_i = 32'hFFFF_FFFE;
        cyc();
        branch_en_i = 1'b0;
        chk("wrap_pre_addr", imem_addr_o, 32'hFFFF_FFFC);
        exp_q.push_back(32'hFFFF_FFFC);
        cyc();
        chk("wrap_addr", imem_addr_o, 32'h0);
        pop_slot("slotFFC");
        exp_q.push_back(32'h0);
        cyc();
        pop_slot("slot0_wrap");
        chk("pre_drain_addr", imem_addr_o, 32'h4);

        // Async reset during DRAIN
        imem_ack_i = 1'b0;
        branch_en_i = 1'b1;
        branch_target_i = 32'h300;
        cyc();
        branch_en_i = 1'b0;
        chk("drain2_req", {31'd0, imem_req_o}, 32'd1);
        chk("drain2_addr", imem_addr_o, 32'h4);
        imem_ack_i = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("async_req", {31'd0, imem_req_o}, 32'd0);
        chk("async_addr", imem_addr_o, 32'h0);
        chk("async_valid", {31'd0, inst_valid_o}, 32'd0);
        cyc();
        chk("inrst_req", {31'd0, imem_req_o}, 32'd0);
        rst = 1'b1;
        imem_ack_i = 1'b0;
        cyc();
        chk("post_rst_req", {31'd0, imem_req_o}, 32'd1);
        chk("post_rst_addr", imem_addr_o, 32'h0);
        chk("post_rst_valid", {31'd0, inst_valid_o}, 32'd0);
        imem_ack_i = 1'b1;
        exp_q.push_back(32'h0);
        cyc();
        pop_slot("post_rst_slot");
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
